// File: rtl/coin_pkg.sv
// Shared definitions for the coin manager: sizes, FSM states and the
// per-level coin placement table.
package coin_pkg;

  localparam int NUM_COINS  = 4;
  localparam int COIN_SIZE  = 3;
  localparam int NUM_LEVELS = 3;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    IDLE = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } coin_slot_t;

  typedef coin_slot_t level_table_t [NUM_LEVELS][NUM_COINS];

  localparam coin_slot_t SLOT_OFF = '{x: 10'd0, y: 10'd0, en: 1'b0};

  localparam level_table_t COIN_TABLE = '{
    '{'{x: 10'd320, y: 10'd240, en: 1'b1}, SLOT_OFF, SLOT_OFF, SLOT_OFF},
    '{'{x: 10'd320, y: 10'd240, en: 1'b1},
      '{x: 10'd200, y: 10'd240, en: 1'b1},
      '{x: 10'd440, y: 10'd240, en: 1'b1}, SLOT_OFF},
    '{'{x: 10'd290, y: 10'd190, en: 1'b1},
      '{x: 10'd350, y: 10'd190, en: 1'b1},
      '{x: 10'd290, y: 10'd290, en: 1'b1},
      '{x: 10'd350, y: 10'd290, en: 1'b1}}
  };

  // Level 3 outranks level 2, which outranks level 1; no select means level 1.
  function automatic logic [1:0] level_index(input logic l1, input logic l2, input logic l3);
    logic [1:0] idx;
    idx = 2'd0;
    if (l3)      idx = 2'd2;
    else if (l2) idx = 2'd1;
    else if (l1) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/coin_hit.sv
// Combinational box-overlap test between the player and one coin.
module coin_hit #(
  parameter int COIN_SIZE = coin_pkg::COIN_SIZE
) (
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] player_s,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  output logic       hit
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic        [10:0] adx;
  logic        [10:0] ady;
  logic        [10:0] limit;

  // One extra bit keeps both the difference and the limit free of wrap.
  assign dx    = $signed({1'b0, player_x}) - $signed({1'b0, coin_x});
  assign dy    = $signed({1'b0, player_y}) - $signed({1'b0, coin_y});
  assign adx   = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady   = dy[10] ? $unsigned(-dy) : $unsigned(dy);
  assign limit = {1'b0, player_s} + 11'(COIN_SIZE);
  assign hit   = (adx <= limit) && (ady <= limit);

endmodule

// File: rtl/coin_manager.sv
// Tracks coin collection for the active level: one slot is overlap-tested
// per cycle after each frame tick, with a combinational draw read port.
module coin_manager #(
  parameter int NUM_COINS = coin_pkg::NUM_COINS,
  parameter int COIN_SIZE = coin_pkg::COIN_SIZE
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 Level1_Active,
  input  logic                 Level2_Active,
  input  logic                 Level3_Active,
  input  logic                 Player_Death,
  input  logic [9:0]           PlayerX,
  input  logic [9:0]           PlayerY,
  input  logic [9:0]           PlayerS,
  input  logic [1:0]           DrawIdx,
  output logic [9:0]           CoinX,
  output logic [9:0]           CoinY,
  output logic [9:0]           CoinS,
  output logic                 CoinVisible,
  output logic [NUM_COINS-1:0] CoinMask,
  output logic [2:0]           CoinCount,
  output logic                 CoinPickup,
  output logic                 AllCollected
);
  import coin_pkg::*;

  localparam int             IW        = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_COINS - 1);
  localparam logic [2:0]     MAX_COUNT = 3'(NUM_COINS);

  state_t               state_reg, state_next;
  logic [1:0]           level_reg, level_sel;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [NUM_COINS-1:0] mask_reg, mask_next, en_mask;
  logic [2:0]           count_reg, count_next;
  logic                 all_reg, all_next;
  logic                 frame_q_reg;
  logic                 frame_edge, force_load, hit, pickup;
  coin_slot_t           scan_slot, draw_slot;

  assign level_sel  = level_index(Level1_Active, Level2_Active, Level3_Active);
  assign frame_edge = frame_clk & ~frame_q_reg;
  // LOAD itself latches the new level, so a mismatch there is not a change.
  assign force_load = Player_Death | ((level_sel != level_reg) && (state_reg != LOAD));

  assign scan_slot = COIN_TABLE[level_reg][idx_reg];
  assign draw_slot = COIN_TABLE[level_reg][DrawIdx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COINS; gi++) begin : g_en
      assign en_mask[gi] = COIN_TABLE[level_reg][gi].en;
    end
  endgenerate

  coin_hit #(.COIN_SIZE(COIN_SIZE)) u_hit (
    .player_x (PlayerX),
    .player_y (PlayerY),
    .player_s (PlayerS),
    .coin_x   (scan_slot.x),
    .coin_y   (scan_slot.y),
    .hit      (hit)
  );

  // An aborting cycle must not report a pickup it will never register.
  assign pickup = (state_reg == SCAN) && !force_load && hit &&
                  scan_slot.en && !mask_reg[idx_reg];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mask_next  = mask_reg;
    count_next = count_reg;
    all_next   = all_reg;
    if (force_load) begin
      state_next = LOAD;
      mask_next  = '0;
      count_next = '0;
      all_next   = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          mask_next  = '0;
          count_next = '0;
          all_next   = 1'b0;
          state_next = IDLE;
        end
        IDLE: begin
          if (frame_edge) begin
            state_next = SCAN;
            idx_next   = '0;
          end
        end
        SCAN: begin
          if (pickup) begin
            mask_next[idx_reg] = 1'b1;
            if (count_reg < MAX_COUNT) count_next = count_reg + 3'd1;
          end
          if (idx_reg == LAST_IDX) state_next = DONE;
          else                     idx_next   = idx_reg + 1'b1;
        end
        DONE: begin
          all_next   = (mask_reg == en_mask);
          state_next = IDLE;
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Sample register resets high so a held-high tick cannot fake an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= LOAD;
      level_reg   <= 2'd0;
      idx_reg     <= '0;
      mask_reg    <= '0;
      count_reg   <= '0;
      all_reg     <= 1'b0;
      frame_q_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      mask_reg    <= mask_next;
      count_reg   <= count_next;
      all_reg     <= all_next;
      frame_q_reg <= frame_clk;
      if (state_reg == LOAD) level_reg <= level_sel;
    end
  end

  assign CoinX        = draw_slot.x;
  assign CoinY        = draw_slot.y;
  assign CoinS        = 10'(COIN_SIZE);
  assign CoinVisible  = draw_slot.en & ~mask_reg[DrawIdx];
  assign CoinMask     = mask_reg;
  assign CoinCount    = count_reg;
  assign CoinPickup   = pickup;
  assign AllCollected = all_reg;

endmodule
